branch_target_predictor: RTL

Dynamic branch predictor and redirect-select unit for the 5-stage RV32 core. Each cycle it looks up the fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters. It then drives the PC register's `Predict_Target_pc` and `PCSel` inputs, raising `Flush` when the EXE stage resolves a misprediction. It trains from EXE-stage branch outcomes and keeps wrap-around performance counters.

---
 rtl/branch_target_predictor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// Branch target predictor and redirect select for the 5-stage RV32 core.
// The direct-mapped BTB has a 2-bit saturating counter per entry. Lookup on
// IF_pc is purely combinational. Training comes from branches resolved in EXE.
// Wrap-around counters track resolved branches and mispredictions.
module branch_target_predictor #(
  parameter int unsigned addrWidth = 16,
  parameter int unsigned ENTRIES   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Hcf,
  input  logic                 Stall,
  input  logic [addrWidth-1:0] IF_pc,
  input  logic                 EXE_is_branch,
  input  logic [addrWidth-1:0] EXE_pc,
  input  logic                 EXE_taken,
  input  logic [addrWidth-1:0] EXE_Target_pc,
  input  logic                 EXE_pred_taken,
  input  logic [addrWidth-1:0] EXE_pred_target,
  output logic                 IF_pred_taken,
  output logic [addrWidth-1:0] Predict_Target_pc,
  output logic [1:0]           PCSel,
  output logic                 Flush,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispredict_cnt
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = addrWidth - IDX - 2;

  localparam logic [1:0] IfPcPlus4  = 2'b00;
  localparam logic [1:0] IfPTPc     = 2'b01;
  localparam logic [1:0] ExeTPc     = 2'b10;
  localparam logic [1:0] ExePcPlus4 = 2'b11;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CtrWeakNt = 2'b01;
  localparam logic [1:0] CtrWeakT  = 2'b10;

  // BTB storage.
  logic                 valid_q  [ENTRIES];
  logic [TAGW-1:0]      tag_q    [ENTRIES];
  logic [addrWidth-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // The byte offset within a word never takes part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{IF_pc[1:0], EXE_pc[1:0]};

  // Fetch-side lookup fields.
  logic [IDX-1:0]  if_idx;
  logic [TAGW-1:0] if_tag;
  logic            if_hit;

  assign if_idx = IF_pc[IDX+1:2];
  assign if_tag = IF_pc[addrWidth-1:IDX+2];

  // Combinational lookup: reads the stored contents, without bypass from EXE.
  always_comb begin
    if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    IF_pred_taken     = if_hit && ctr_q[if_idx][1];
    Predict_Target_pc = if_hit ? target_q[if_idx] : '0;
  end

  // Mispredict detection on the resolving EXE instruction.
  logic mispredict;

  always_comb begin
    mispredict = 1'b0;
    if (EXE_is_branch) begin
      if (EXE_taken != EXE_pred_taken) begin
        mispredict = 1'b1;
      end else if (EXE_taken && (EXE_Target_pc != EXE_pred_target)) begin
        mispredict = 1'b1;
      end
    end
  end

  assign Flush = mispredict;

  // Next-PC select. An EXE redirect takes precedence over the fetch prediction.
  always_comb begin
    PCSel = IfPcPlus4;
    if (mispredict && EXE_taken) begin
      PCSel = ExeTPc;
    end else if (mispredict) begin
      PCSel = ExePcPlus4;
    end else if (IF_pred_taken) begin
      PCSel = IfPTPc;
    end
  end

  // EXE-side training fields.
  logic [IDX-1:0]  ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;
  logic            upd_en;
  logic [1:0]      ex_ctr_d;

  assign ex_idx = EXE_pc[IDX+1:2];
  assign ex_tag = EXE_pc[addrWidth-1:IDX+2];
  assign upd_en = EXE_is_branch && !Stall && !Hcf;

  // Saturating counter step for the entry that is being trained.
  always_comb begin
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_ctr_d = ctr_q[ex_idx];
    if (EXE_taken) begin
      if (ctr_q[ex_idx] != 2'b11) begin
        ex_ctr_d = ctr_q[ex_idx] + 2'd1;
      end
    end else begin
      if (ctr_q[ex_idx] != 2'b00) begin
        ex_ctr_d = ctr_q[ex_idx] - 2'd1;
      end
    end
  end

  // Performance counter next state; both wrap naturally at 32 bits.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (upd_en) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict) begin
        mispredict_cnt_d = mispredict_cnt_q + 32'd1;
      end
    end
  end

  // BTB update. A taken miss allocates and evicts whatever aliases that index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrWeakNt;
      end
    end else if (upd_en) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ex_ctr_d;
        if (EXE_taken) begin
          target_q[ex_idx] <= EXE_Target_pc;
        end
      end else if (EXE_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= EXE_Target_pc;
        ctr_q[ex_idx]    <= CtrWeakT;
      end
    end
  end

  // Performance counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
